posit_result_checker: RTL
=========================

Name: posit_result_checker

Overview:
- Synthesizable end-of-stream checker for the posit adder datapath.
- Accepts a valid/ready stream of (DUT result, golden result) pairs and computes the absolute bit-pattern difference per pair.
- Accumulates match and error statistics over a programmed vector count, then raises done.
- Replaces file-based diff logging for FPGA and emulation runs of Posit_Adder.

Parameters:
N, 8, posit width in bits.
CNT_W, 17, counter width; must cover 65536 vectors.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; clears statistics and arms a run.
num_vectors  in  CNT_W  pairs expected in this run; sampled on start.
in_valid  in  1  pair valid.
in_ready  out  1  checker can accept a pair.
dut_out  in  N  posit result from the adder.
golden  in  N  expected posit result.
busy  out  1  run in progress.
done  out  1  held high after the run completes, until the next start.
total_cnt  out  CNT_W  pairs accepted.
match_cnt  out  CNT_W  pairs with diff == 0.
ulp1_cnt  out  CNT_W  pairs with diff == 1.
err_cnt  out  CNT_W  pairs with diff > 1.
max_diff  out  N  largest diff seen.
first_err_idx  out  CNT_W  index (0-based) of the first pair with diff > 1.
first_err_vld  out  1  first_err_idx is meaningful.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - All outputs 0, including in_ready, busy, done and every counter.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. If num_vectors == 0: IDLE -> DONE directly, done high next cycle, all counters 0.
  - RUN -> DRAIN on the cycle the num_vectors-th pair is accepted.
  - DRAIN -> DONE once the pipeline is empty (2 cycles after the last accept).
  - DONE -> RUN on start, which clears statistics in the same edge.
  - start in RUN or DRAIN is ignored.
- Handshake:
  - in_ready = (state == RUN) and accepted_count < num_vectors_latched.
  - A transfer occurs when in_valid && in_ready on a rising edge.
  - in_valid may drop at any time; no transfer occurs that cycle.
- Arithmetic:
  - diff = (golden > dut_out) ? golden - dut_out : dut_out - golden, on N-bit unsigned patterns (no posit decode).
  - NaR (1 followed by zeros) is treated as a plain pattern.
- Pipeline:
  - Stage 1 registers diff plus a valid tag and the index.
  - Stage 2 updates counters, max_diff and first-error capture.
  - Counters reflect a pair 2 cycles after its transfer.
  - busy = (state == RUN or DRAIN).
  - done rises in the cycle after the final stage-2 update.
- Counters:
  - Saturate at all-ones; no wrap.
  - Invariant: total_cnt == match_cnt + ulp1_cnt + err_cnt unless saturated.
- first_err_idx: captured only on the first diff > 1 of a run; first_err_vld set at that point; later errors do not overwrite.
- Reset mid-run: immediate return to IDLE with all state cleared; in-flight pairs are discarded.

Test Plan:
- Reset, then start with num_vectors=4 and pairs (0x40,0x40), (0x41,0x40), (0x10,0x13), (0x7F,0x7F) -> total=4, match=2, ulp1=1, err=1, max_diff=3, first_err_idx=2, first_err_vld=1; done high 2 cycles after the 4th accept.
- Random in_valid gaps over 16 matching pairs -> match=16; in_ready low after the 16th accept; no extra beats counted while in_valid stays high.
- Wrap-extreme pair (dut_out=0x00, golden=0xFF) -> diff=0xFF, max_diff=0xFF, err=1.
- start with num_vectors=0 -> done=1 the next cycle, in_ready never high, counters 0.
- Drop rst_n low mid-run after 3 accepts -> all outputs 0 asynchronously; a new start with 2 matching pairs yields total=2, first_err_vld=0.
- start pulsed during RUN -> ignored, counts continue; start in DONE -> counters cleared, new run proceeds.

Source files
------------

// File: rtl/posit_result_checker.sv
// posit_result_checker
// End-of-stream checker for the posit adder datapath. Consumes a valid/ready
// stream of (dut_out, golden) pairs, computes the absolute bit-pattern
// difference of each pair, and gathers match / one-ulp / error statistics
// over a programmed number of vectors before raising done.
module posit_result_checker #(
  parameter int N     = 8,
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dut_out,
  input  logic [N-1:0]     golden,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] ulp1_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [N-1:0]     max_diff,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             first_err_vld
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [N-1:0]     DIFF_ZERO = '0;
  localparam logic [N-1:0]     DIFF_ONE  = {{(N-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] nvec_q, nvec_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             s1_vld_q, s1_vld_d;
  logic [N-1:0]     s1_diff_q, s1_diff_d;
  logic [CNT_W-1:0] s1_idx_q, s1_idx_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] ulp1_q, ulp1_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [N-1:0]     max_diff_q, max_diff_d;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             first_err_vld_q, first_err_vld_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             transfer;
  logic             clear_stats;
  logic [N-1:0]     pair_diff;
  logic [CNT_W-1:0] acc_inc;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign transfer  = in_valid && in_ready_q;
  assign acc_inc   = acc_q + CNT_ONE;
  assign pair_diff = (golden > dut_out) ? (golden - dut_out) : (dut_out - golden);

  // Run control and stage 1: FSM sequencing, acceptance counting, diff capture.
  always_comb begin
    state_d     = state_q;
    nvec_d      = nvec_q;
    acc_d       = acc_q;
    s1_vld_d    = 1'b0;
    s1_diff_d   = s1_diff_q;
    s1_idx_d    = s1_idx_q;
    clear_stats = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          nvec_d      = num_vectors;
          acc_d       = CNT_ZERO;
          clear_stats = 1'b1;
          state_d     = (num_vectors == CNT_ZERO) ? DONE : RUN;
        end
      end
      RUN: begin
        if (transfer) begin
          s1_vld_d  = 1'b1;
          s1_diff_d = pair_diff;
          s1_idx_d  = acc_q;
          acc_d     = acc_inc;
          if (acc_inc == nvec_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!s1_vld_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 2: fold the registered diff into the run statistics.
  always_comb begin
    total_d         = total_q;
    match_d         = match_q;
    ulp1_d          = ulp1_q;
    err_d           = err_q;
    max_diff_d      = max_diff_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    if (clear_stats) begin
      total_d         = CNT_ZERO;
      match_d         = CNT_ZERO;
      ulp1_d          = CNT_ZERO;
      err_d           = CNT_ZERO;
      max_diff_d      = DIFF_ZERO;
      first_err_idx_d = CNT_ZERO;
      first_err_vld_d = 1'b0;
    end else if (s1_vld_q) begin
      total_d = sat_inc(total_q);
      if (s1_diff_q == DIFF_ZERO) begin
        match_d = sat_inc(match_q);
      end else if (s1_diff_q == DIFF_ONE) begin
        ulp1_d = sat_inc(ulp1_q);
      end else begin
        err_d = sat_inc(err_q);
        if (!first_err_vld_q) begin
          first_err_idx_d = s1_idx_q;
          first_err_vld_d = 1'b1;
        end
      end
      if (s1_diff_q > max_diff_q) begin
        max_diff_d = s1_diff_q;
      end
    end
  end

  // Status outputs are computed from the next state so they come straight from flops.
  always_comb begin
    in_ready_d = (state_d == RUN) && (acc_d < nvec_d);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // State register; an asynchronous reset discards any in-flight pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      nvec_q          <= '0;
      acc_q           <= '0;
      s1_vld_q        <= 1'b0;
      s1_diff_q       <= '0;
      s1_idx_q        <= '0;
      total_q         <= '0;
      match_q         <= '0;
      ulp1_q          <= '0;
      err_q           <= '0;
      max_diff_q      <= '0;
      first_err_idx_q <= '0;
      first_err_vld_q <= 1'b0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      nvec_q          <= nvec_d;
      acc_q           <= acc_d;
      s1_vld_q        <= s1_vld_d;
      s1_diff_q       <= s1_diff_d;
      s1_idx_q        <= s1_idx_d;
      total_q         <= total_d;
      match_q         <= match_d;
      ulp1_q          <= ulp1_d;
      err_q           <= err_d;
      max_diff_q      <= max_diff_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
      in_ready_q      <= in_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign total_cnt     = total_q;
  assign match_cnt     = match_q;
  assign ulp1_cnt      = ulp1_q;
  assign err_cnt       = err_q;
  assign max_diff      = max_diff_q;
  assign first_err_idx = first_err_idx_q;
  assign first_err_vld = first_err_vld_q;

endmodule
